// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic scheduler: default widths, opcodes and FSM states.
package arith_pkg;

   localparam int A_W_DEF   = 11;
   localparam int B_W_DEF   = 8;
   localparam int RES_W_DEF = A_W_DEF + B_W_DEF;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DIV  = 2'd2,
      S_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle, A_W cycles per divide.
module seq_divider #(
   parameter int A_W = 11,
   parameter int B_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [A_W-1:0] dividend,
   input  logic [B_W-1:0] divisor,
   output logic           done,
   output logic [A_W-1:0] quotient,
   output logic [B_W-1:0] remainder
);

   localparam int CNT_W = $clog2(A_W);

   logic [A_W-1:0]   quo_q, quo_d;
   logic [B_W-1:0]   rem_q, rem_d;
   logic [B_W-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [B_W:0]     shifted;
   logic [B_W+1:0]   trial;
   logic [B_W:0]     rem_full;

   always_comb begin
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      shifted  = {rem_q, quo_q[A_W-1]};
      trial    = {1'b0, shifted} - {2'b00, dvs_q};
      rem_full = trial[B_W+1] ? shifted : trial[B_W:0];
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = CNT_W'(A_W - 1);
         run_d = 1'b1;
      end else if (run_q) begin
         // The partial remainder always stays below the divisor, so B_W bits suffice
         rem_d = B_W'(rem_full);
         quo_d = {quo_q[A_W-2:0], ~trial[B_W+1]};
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign done      = run_q && (cnt_q == '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/arith_sched.sv
// Round-robin scheduler sharing one add/sub/mul/div engine between two requesters.
module arith_sched
   import arith_pkg::*;
#(
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int RES_W = A_W + B_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [A_W-1:0]   req0_a,
   input  logic [B_W-1:0]   req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [A_W-1:0]   req1_a,
   input  logic [B_W-1:0]   req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [RES_W-1:0] rsp_result,
   output logic             rsp_flag,
   output logic             rsp_err,
   output logic             busy
);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0]       op_q, op_d;
   logic [A_W-1:0]   a_q, a_d;
   logic [B_W-1:0]   b_q, b_d;
   logic             id_q, id_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             flag_q, flag_d;
   logic             err_q, err_d;

   logic             grant;
   logic             accept;
   logic [1:0]       sel_op;
   logic [A_W-1:0]   sel_a;
   logic [B_W-1:0]   sel_b;
   logic [A_W-1:0]   b_ext;
   logic [A_W:0]     sum;
   logic [A_W-1:0]   diff;
   logic [RES_W-1:0] prod;
   logic             div_start;
   logic             div_done;
   logic [A_W-1:0]   div_quo;
   logic [B_W-1:0]   div_rem;

   // Tie goes to whichever requester was not served last
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
      accept    = (state_q == S_IDLE) && (req0_valid || req1_valid);
      sel_op    = grant ? req1_op : req0_op;
      sel_a     = grant ? req1_a  : req0_a;
      sel_b     = grant ? req1_b  : req0_b;
      div_start = accept && (sel_op == OP_DIV) && (sel_b != '0);
   end

   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

   always_comb begin
      b_ext = {{(A_W-B_W){1'b0}}, b_q};
      sum   = {1'b0, a_q} + {1'b0, b_ext};
      diff  = a_q - b_ext;
      prod  = RES_W'(a_q) * RES_W'(b_q);
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      result_d     = result_q;
      flag_d       = flag_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d         = sel_op;
               a_d          = sel_a;
               b_d          = sel_b;
               id_d         = grant;
               last_grant_d = grant;
               state_d      = div_start ? S_DIV : S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = '0;
            flag_d   = 1'b0;
            err_d    = 1'b0;
            case (op_q)
               OP_ADD: begin
                  result_d = RES_W'(sum);
                  flag_d   = sum[A_W];
               end
               OP_SUB: begin
                  result_d = RES_W'(diff);
                  flag_d   = a_q < b_ext;
               end
               OP_MUL:  result_d = prod;
               default: err_d = 1'b1;
            endcase
            state_d = S_RESP;
         end
         S_DIV: begin
            if (div_done) begin
               flag_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= OP_ADD;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         result_q     <= '0;
         flag_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         result_q     <= result_d;
         flag_q       <= flag_d;
         err_q        <= err_d;
      end
   end

   seq_divider #(
      .A_W(A_W),
      .B_W(B_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (sel_a),
      .divisor  (sel_b),
      .done     (div_done),
      .quotient (div_quo),
      .remainder(div_rem)
   );

   // The divider holds its final quotient/remainder, so division results are read from it directly
   assign rsp_result = (op_q == OP_DIV && !err_q) ? {div_rem, div_quo} : result_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_id     = id_q;
   assign rsp_flag   = flag_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule
